// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the request/handshake signals between the requesters, the memory
// and the shared-port arbiter.
//   req        requester levels, bit i = requester i
//   mem_ready  memory-done indication
//   grant      one-hot owner of the memory port (0 when idle)
//   sel        index of the granted requester, drives the 4-to-1 addr/data mux
//   mem_start  one-cycle memory access start strobe
//   ack        one-hot one-cycle completion pulse to the owner
//   err        one-cycle pulse alongside ack when the access timed out
//   busy       arbiter is not idle
// Modports: master = requester/memory side, slave = arbiter side.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
    logic [3:0] req;
    logic       mem_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_start;
    logic [3:0] ack;
    logic       err;
    logic       busy;

    modport master (
        output req, mem_ready,
        input  grant, sel, mem_start, ack, err, busy
    );

    modport slave (
        input  req, mem_ready,
        output grant, sel, mem_start, ack, err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates four requesters onto the single shared memory port of the
// multi-cycle CPU: picks a winner, drives the port mux select, issues a start
// strobe, waits for the memory and returns a completion pulse. A per-access
// timeout of TIMEOUT wait cycles guarantees forward progress.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_port_arbiter_if.slave (req, mem_ready in; grant, sel,
//        mem_start, ack, err, busy out -- all outputs registered)
// Parameters:
//   TIMEOUT  maximum WAIT cycles per access, 1..255
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined: round-robin winner search starting at a
//                           rotating pointer; undefined: fixed priority with
//                           req[0] highest.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] grant_q;
    logic [1:0] sel_q;
    logic       mem_start_q;
    logic [3:0] ack_q;
    logic       err_q;
    logic       busy_q;
    logic [7:0] cnt;
    logic [1:0] ptr;
    logic [1:0] win;

    // First set request bit scanning start, start+1, ... modulo 4. Scanning
    // from the far end lets the closest hit overwrite the result last.
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] start);
        logic [1:0] idx;
        pick_winner = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) pick_winner = idx;
        end
    endfunction

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority is the round-robin search anchored at requester 0.
    assign ptr = 2'd0;
`endif

    always_comb begin
        win = pick_winner(bus.req, ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= 4'd0;
            sel_q       <= 2'd0;
            mem_start_q <= 1'b0;
            ack_q       <= 4'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt         <= 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr         <= 2'd0;
`endif
        end else begin
            // Strobes default low; each is raised for exactly one cycle.
            mem_start_q <= 1'b0;
            ack_q       <= 4'd0;
            err_q       <= 1'b0;
            case (state)
                IDLE: begin
                    // Outputs are registered, so the ISSUE-cycle values are
                    // loaded on the way into ISSUE.
                    if (bus.req != 4'd0) begin
                        state       <= ISSUE;
                        grant_q     <= 4'b0001 << win;
                        sel_q       <= win;
                        mem_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= 8'd0;
                end
                WAIT: begin
                    if (bus.mem_ready || cnt == CNT_LAST) begin
                        state   <= IDLE;
                        ack_q   <= 4'b0001 << sel_q;
                        err_q   <= ~bus.mem_ready;
                        grant_q <= 4'd0;
                        busy_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        ptr     <= sel_q + 2'd1;
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.mem_start = mem_start_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter. Each transaction pushes
// its expected completion (ack, err, cycles until ack) onto a scoreboard
// queue when the request is driven; the entry is popped and compared when the
// arbiter produces its ack. The winner model follows the build option.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int TB_TIMEOUT = 16;

    typedef struct {
        logic [3:0] ack;
        logic       err;
        int         steps;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   mptr     = 0;
    exp_t sb[$];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [3:0] r, input int p);
        int idx;
        for (int i = 0; i < 4; i++) begin
            idx = (p + i) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_sel"}, 32'(bus.sel), 32'd0);
        check({tag, "_start"}, 32'(bus.mem_start), 32'd0);
        check({tag, "_ack"}, 32'(bus.ack), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = 4'd0;
        bus.mem_ready = 1'b0;
        step();
        check_reset_values("reset");
        rst  = 1'b0;
        mptr = 0;
    endtask

    // Idle cycles with no request; mem_ready held high must be ignored.
    task automatic idle_cycles(input int n);
        bus.req       = 4'd0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_grant", 32'(bus.grant), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_ack", 32'(bus.ack), 32'd0);
            check("idle_start", 32'(bus.mem_start), 32'd0);
        end
        bus.mem_ready = 1'b0;
    endtask

    // One transaction from IDLE. mem_ready rises on WAIT cycle index d
    // (0-based); d >= TB_TIMEOUT means it never rises. drop releases the
    // winner's request after ISSUE; early holds mem_ready high in IDLE/ISSUE.
    task automatic run_txn(input logic [3:0] r, input int d, input bit drop,
                           input bit early);
        int   w;
        int   k;
        bit   got;
        exp_t e;
        bus.req       = r;
        bus.mem_ready = early;
        w = model_winner(r, mptr);
        e.ack   = 4'b0001 << w;
        e.err   = (d >= TB_TIMEOUT);
        e.steps = (d >= TB_TIMEOUT) ? TB_TIMEOUT + 1 : d + 2;
        sb.push_back(e);
        step();
        check("issue_grant", 32'(bus.grant), 32'(4'b0001 << w));
        check("issue_sel", 32'(bus.sel), 32'(w));
        check("issue_start", 32'(bus.mem_start), 32'd1);
        check("issue_busy", 32'(bus.busy), 32'd1);
        check("issue_ack", 32'(bus.ack), 32'd0);
        check("issue_err", 32'(bus.err), 32'd0);
        if (drop) bus.req = r & ~(4'b0001 << w);
        k   = 0;
        got = 1'b0;
        while (k < 300 && !got) begin
            step();
            k++;
            if (bus.ack != 4'd0) begin
                got = 1'b1;
            end else begin
                check("wait_grant", 32'(bus.grant), 32'(4'b0001 << w));
                check("wait_sel", 32'(bus.sel), 32'(w));
                check("wait_start", 32'(bus.mem_start), 32'd0);
                check("wait_busy", 32'(bus.busy), 32'd1);
                bus.mem_ready = ((k - 1) >= d);
            end
        end
        bus.mem_ready = 1'b0;
        e = sb.pop_front();
        check("ack_seen", 32'(got), 32'd1);
        check("ack_cycles", 32'(k), 32'(e.steps));
        check("ack_value", 32'(bus.ack), 32'(e.ack));
        check("ack_err", 32'(bus.err), 32'(e.err));
        check("done_grant", 32'(bus.grant), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_sel", 32'(bus.sel), 32'(w));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        mptr = (w + 1) % 4;
`endif
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = 4'd0;
        bus.mem_ready = 1'b0;
        step();
        do_reset();

        // Single request, ready on first WAIT cycle.
        run_txn(4'b0100, 0, 1'b0, 1'b0);
        idle_cycles(2);

        // All requesting, ready immediately, back to back from reset.
        do_reset();
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 1'b0, 1'b0);
        bus.req = 4'd0;
        step();
        check("post_burst_ack", 32'(bus.ack), 32'd0);

        // Timeout, then a full request shows where the pointer landed.
        run_txn(4'b0010, 99, 1'b0, 1'b0);
        run_txn(4'b1111, 1, 1'b0, 1'b0);

        // Requester 3, request dropped mid-access, pointer wraps to 0.
        run_txn(4'b1000, 5, 1'b1, 1'b0);
        run_txn(4'b1111, 2, 1'b0, 1'b0);

        // Reset on the third WAIT cycle abandons the access.
        bus.req       = 4'b0100;
        bus.mem_ready = 1'b0;
        step();
        check("rst_issue_grant", 32'(bus.grant), 32'(4'b0001 << model_winner(4'b0100, mptr)));
        bus.req = 4'd0;
        step();
        step();
        step();
        check("rst_wait_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        check_reset_values("midrst");
        rst  = 1'b0;
        mptr = 0;
        idle_cycles(3);
        run_txn(4'b0110, 0, 1'b0, 1'b0);

        // mem_ready high only during IDLE/ISSUE must not complete the access.
        run_txn(4'b0001, 3, 1'b0, 1'b1);
        run_txn(4'b1000, TB_TIMEOUT - 1, 1'b0, 1'b1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
